// File: rtl/serdes_tx_ctrl_if.sv
// Parallel word handshake between a word source and serdes_tx_ctrl.
// The source drives data_in/data_valid; the controller returns data_ready.
interface serdes_tx_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/serdes_tx_ctrl.sv
// Serdes transmit controller: captures a parallel word on handshake and shifts it out
// one bit per enabled clock with frame strobe and inter-word gap. Define PARITY_EN to
// append an even-parity bit to every frame.
module serdes_tx_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  serdes_tx_ctrl_if.slave   word,
  output logic              ser_out,
  output logic              ser_frame,
  output logic              busy,
  output logic              word_done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] LastGap = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             ser_out_d, ser_frame_d, busy_d, word_done_d;
  logic             done_pend_q, done_pend_d;
  logic [WIDTH-1:0] data_in;
  logic             handshake;
`ifdef PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign data_in         = word.data_in;
  assign word.data_ready = enb & (state_q == StIdle);
  assign handshake       = word.data_valid & word.data_ready;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_out_d   = ser_out;
    ser_frame_d = ser_frame;
    word_done_d = 1'b0;
    done_pend_d = done_pend_q;
`ifdef PARITY_EN
    parity_d    = parity_q;
`endif

    if (!enb) begin
      // A pulse that ends on a frozen edge was never consumed; replay it on resume.
      if (word_done) begin
        done_pend_d = 1'b1;
      end
    end else begin
      if (done_pend_q) begin
        word_done_d = 1'b1;
        done_pend_d = 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          ser_out_d   = 1'b0;
          ser_frame_d = 1'b0;
          if (handshake) begin
            // First bit goes straight from data_in so it appears the cycle after capture.
            shift_d     = shift_word(data_in);
            ser_out_d   = head_bit(data_in);
            ser_frame_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = StShift;
`ifdef PARITY_EN
            parity_d    = ^data_in;
`endif
          end
        end
        StShift: begin
          if (bit_cnt_q == LastBit) begin
`ifdef PARITY_EN
            state_d     = StParity;
            ser_out_d   = parity_q;
            ser_frame_d = 1'b1;
`else
            state_d     = StGap;
            ser_out_d   = 1'b0;
            ser_frame_d = 1'b0;
            word_done_d = 1'b1;
            gap_cnt_d   = '0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            ser_out_d = head_bit(shift_q);
            shift_d   = shift_word(shift_q);
          end
        end
        StParity: begin
          state_d     = StGap;
          ser_out_d   = 1'b0;
          ser_frame_d = 1'b0;
          word_done_d = 1'b1;
          gap_cnt_d   = '0;
        end
        StGap: begin
          ser_out_d   = 1'b0;
          ser_frame_d = 1'b0;
          if (gap_cnt_q == LastGap) begin
            state_d = StIdle;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_out     <= 1'b0;
      ser_frame   <= 1'b0;
      busy        <= 1'b0;
      word_done   <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_out     <= ser_out_d;
      ser_frame   <= ser_frame_d;
      busy        <= busy_d;
      word_done   <= word_done_d;
      done_pend_q <= done_pend_d;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_serdes_tx_ctrl.sv
// Directed bench for serdes_tx_ctrl: an MSB-first and an LSB-first instance, stimulus
// driven and outputs sampled on the falling edge.
module tb_serdes_tx_ctrl;

`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int W = 8;

  logic clk, reset, enb;
  logic so_m, sf_m, bz_m, wd_m;
  logic so_l, sf_l, bz_l, wd_l;
  logic sel;
  logic so, sf, bz, wd, rdy;
  int   n_checks, n_errors;

  serdes_tx_ctrl_if #(.WIDTH(W)) if_m ();
  serdes_tx_ctrl_if #(.WIDTH(W)) if_l ();

  serdes_tx_ctrl #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .word      (if_m),
    .ser_out   (so_m),
    .ser_frame (sf_m),
    .busy      (bz_m),
    .word_done (wd_m)
  );

  serdes_tx_ctrl #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .word      (if_l),
    .ser_out   (so_l),
    .ser_frame (sf_l),
    .busy      (bz_l),
    .word_done (wd_l)
  );

  always_comb begin
    so  = sel ? so_l : so_m;
    sf  = sel ? sf_l : sf_m;
    bz  = sel ? bz_l : bz_m;
    wd  = sel ? wd_l : wd_m;
    rdy = sel ? if_l.data_ready : if_m.data_ready;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) if_l.data_valid = v;
    else     if_m.data_valid = v;
  endtask

  task automatic set_data(input logic [7:0] d);
    if_m.data_in = d;
    if_l.data_in = d;
  endtask

  // Called on a falling edge with the selected instance idle.
  task automatic send_frame(input logic [7:0] w, input logic lsb, input bit toggle,
                            input int stall_after, input string tag);
    logic [7:0] stream;
    logic [7:0] d;
    logic       held;
    sel = lsb;
    d   = w;
    set_data(d);
    set_valid(1'b1);
    #1;
    check_val({tag, "_rdy"}, 32'(rdy), 32'd1);
    @(posedge clk);
    stream = '0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (i == 1) set_valid(1'b0);
      if (toggle) begin
        d = ~d;
        set_data(d);
      end
      check_val($sformatf("%s_frame%0d", tag, i), 32'(sf), 32'd1);
      if (lsb) stream[i-1] = so;
      else     stream[W-i] = so;
      if (i == stall_after) begin
        held = so;
        enb  = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_val({tag, "_hold_out"}, 32'(so), 32'(held));
          check_val({tag, "_hold_frame"}, 32'(sf), 32'd1);
          check_val({tag, "_hold_rdy"}, 32'(rdy), 32'd0);
        end
        enb = 1'b1;
      end
    end
    check_val({tag, "_stream"}, 32'(stream), 32'(w));
`ifdef PARITY_EN
    @(negedge clk);
    check_val({tag, "_par_frame"}, 32'(sf), 32'd1);
    check_val({tag, "_par_bit"}, 32'(so), 32'(^w));
`endif
    @(negedge clk);
    check_val({tag, "_gap"}, 32'({sf, so, wd, bz}), 32'b0011);
    @(negedge clk);
    check_val({tag, "_idle"}, 32'({wd, bz, rdy}), 32'b001);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((bz || !rdy) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'({bz, rdy}), 32'b01);
  endtask

  initial begin
    logic       fr [0:31];
    logic       ob [0:31];
    logic [7:0] s1, s2;
    int         start2;
    logic       saw_wd;

    n_checks = 0;
    n_errors = 0;
    sel      = 1'b0;
    reset    = 1'b1;
    enb      = 1'b1;
    if_m.data_in = '0; if_m.data_valid = 1'b0;
    if_l.data_in = '0; if_l.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_out", 32'({so_m, sf_m, bz_m, wd_m}), 32'b0000);
    check_val("reset_rdy", 32'(if_m.data_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Basic MSB-first frame
    send_frame(8'b1000_1000, 1'b0, 1'b0, 0, "t1");

    // Back-to-back with data_valid held high
    sel = 1'b0;
    set_data(8'h01);
    set_valid(1'b1);
    @(posedge clk);
    start2 = -1;
    for (int n = 1; n <= 20 + P; n++) begin
      @(negedge clk);
      if (n == 1) set_data(8'hFF);
      fr[n] = sf;
      ob[n] = so;
      if (n > 1 && sf && !fr[n-1] && start2 < 0) start2 = n;
      if (n == 18 + P) set_valid(1'b0);
    end
    check_val("t2_start2", 32'(start2), 32'(11 + P));
    for (int i = 0; i < W; i++) begin
      s1[W-1-i] = ob[1 + i];
      s2[W-1-i] = ob[11 + P + i];
    end
    check_val("t2_word1", 32'(s1), 32'h01);
    check_val("t2_word2", 32'(s2), 32'hFF);
`ifdef PARITY_EN
    check_val("t2_par1", 32'(ob[9]), 32'd1);
    check_val("t2_par2", 32'(ob[20]), 32'd0);
`endif
    wait_idle("t2_idle");

    // Enable stall after the 4th bit
    send_frame(8'hA5, 1'b0, 1'b0, 4, "t3");

    // Reset mid-frame after the 5th bit
    sel = 1'b0;
    set_data(8'h3C);
    set_valid(1'b1);
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) set_valid(1'b0);
    end
    check_val("t4_bit5", 32'(so), 32'd1);
    reset = 1'b1;
    #1;
    check_val("t4_abort", 32'({so, sf, bz, wd}), 32'b0000);
    @(negedge clk);
    reset  = 1'b0;
    saw_wd = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (wd) saw_wd = 1'b1;
    end
    check_val("t4_no_done", 32'(saw_wd), 32'd0);
    send_frame(8'hC3, 1'b0, 1'b0, 0, "t4b");

    // LSB-first instance
    send_frame(8'b1000_1000, 1'b1, 1'b0, 0, "t5");

    // data_in toggling after capture
    send_frame(8'h5A, 1'b0, 1'b1, 0, "t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
